// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU issue stage: select codes,
//                datapath width and the packed command layout {acc,sel,a,b}.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    // ALU select codes
    localparam logic [2:0] SEL_PASS_A   = 3'b000;  // A
    localparam logic [2:0] SEL_INC_A    = 3'b001;  // A + 1
    localparam logic [2:0] SEL_ADD      = 3'b010;  // A + B
    localparam logic [2:0] SEL_ADD_INC  = 3'b011;  // A + B + 1
    localparam logic [2:0] SEL_ADD_NOTB = 3'b100;  // A + ~B
    localparam logic [2:0] SEL_SUB      = 3'b101;  // A - B
    localparam logic [2:0] SEL_DEC_A    = 3'b110;  // A - 1
    localparam logic [2:0] SEL_PASS_B   = 3'b111;  // B

    // Command entry as stored in the FIFO: {acc, sel, a, b}
    typedef struct packed {
        logic                  acc;
        logic [2:0]            sel;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
    } alu_cmd_t;

    localparam int CMD_W       = 1 + 3 + 2 * ALU_DATA_W;  // 68
    localparam int CMD_B_LSB   = 0;
    localparam int CMD_A_LSB   = ALU_DATA_W;
    localparam int CMD_SEL_LSB = 2 * ALU_DATA_W;
    localparam int CMD_ACC_BIT = 2 * ALU_DATA_W + 3;

endpackage
`default_nettype wire

// File: rtl/alu32.sv
`default_nettype none
// ============================================================================
//  Module      : alu32
//  Description : Combinational 32-bit arithmetic unit, eight operations
//                selected by a 3-bit code. Results are mod 2^32.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu32
    import alu_pkg::*;
(
    input  wire logic [2:0]            i_sel,
    input  wire logic [ALU_DATA_W-1:0] i_a,
    input  wire logic [ALU_DATA_W-1:0] i_b,
    output logic      [ALU_DATA_W-1:0] o_result
);

    // Operation decode; carry-out is simply truncated
    always_comb begin
        o_result = '0;
        case (i_sel)
            SEL_PASS_A:   o_result = i_a;
            SEL_INC_A:    o_result = i_a + ALU_DATA_W'(1);
            SEL_ADD:      o_result = i_a + i_b;
            SEL_ADD_INC:  o_result = i_a + i_b + ALU_DATA_W'(1);
            SEL_ADD_NOTB: o_result = i_a + ~i_b;
            SEL_SUB:      o_result = i_a - i_b;
            SEL_DEC_A:    o_result = i_a - ALU_DATA_W'(1);
            SEL_PASS_B:   o_result = i_b;
            default:      o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_fifo
//  Description : Synchronous FIFO of command entries. Pointers carry one
//                extra wrap bit to distinguish full from empty. A push while
//                full is refused even if a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wr_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push    = i_push & ~o_full;
    assign w_pop     = i_pop & ~o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    // Read/write pointer advance with wrap bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Command FIFO in front of a 32-bit ALU. Issues one command per
//                cycle when the registered output slot is free or draining,
//                keeps a running accumulator and an issued-op counter.
//                Optional macro ALU_FLAGS_EN adds registered zero/neg flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              in_valid,
    output logic                   in_ready,
    input  wire logic [2:0]        in_sel,
    input  wire logic [DATA_W-1:0] in_a,
    input  wire logic [DATA_W-1:0] in_b,
    input  wire logic              in_acc,
    input  wire logic              acc_clr,
    output logic                   out_valid,
    input  wire logic              out_ready,
    output logic      [DATA_W-1:0] out_data,
    output logic      [DATA_W-1:0] acc_q,
`ifdef ALU_FLAGS_EN
    output logic                   out_zero,
    output logic                   out_neg,
`endif
    output logic      [CNT_W-1:0]  issued_cnt
);

    alu_cmd_t          w_wr_cmd;
    alu_cmd_t          w_head;
    logic [CMD_W-1:0]  w_head_bits;
    logic              w_full;
    logic              w_empty;
    logic              w_issue;
    logic [DATA_W-1:0] w_a_eff;
    logic [DATA_W-1:0] w_result;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_issued_cnt;

    assign w_wr_cmd = '{acc: in_acc, sel: in_sel, a: in_a, b: in_b};
    assign w_head   = alu_cmd_t'(w_head_bits);

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (in_valid),
        .i_wr_data (w_wr_cmd),
        .i_pop     (w_issue),
        .o_rd_data (w_head_bits),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // The output slot accepts a new result when empty or being drained now
    assign w_issue  = ~w_empty & (~r_out_valid | out_ready);
    assign in_ready = ~w_full;

    // Accumulator operand is resolved at issue, so chained acc commands see
    // the value written on the previous edge
    assign w_a_eff  = w_head.acc ? r_acc : w_head.a;

    alu32 u_alu (
        .i_sel    (w_head.sel),
        .i_a      (w_a_eff),
        .i_b      (w_head.b),
        .o_result (w_result)
    );

    // Result register, output handshake, accumulator and issue counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_acc        <= '0;
            r_issued_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= w_result;
                r_acc        <= w_result;
                r_issued_cnt <= r_issued_cnt + CNT_W'(1);
            end else if (out_ready) begin
                r_out_valid  <= 1'b0;
            end
            // Clear overrides the accumulator write of a concurrent issue
            if (acc_clr) begin
                r_acc <= '0;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    logic r_out_zero;
    logic r_out_neg;

    // Flags track the result register and hold with it under stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_zero <= 1'b0;
            r_out_neg  <= 1'b0;
        end else if (w_issue) begin
            r_out_zero <= (w_result == '0);
            r_out_neg  <= w_result[DATA_W-1];
        end
    end

    assign out_zero = r_out_zero;
    assign out_neg  = r_out_neg;
`endif

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign acc_q      = r_acc;
    assign issued_cnt = r_issued_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Self-checking bench for alu_issue_stage: directed scenarios
//                followed by randomized traffic against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_acc;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] acc_q;
    logic [15:0] issued_cnt;
`ifdef ALU_FLAGS_EN
    logic        out_zero;
    logic        out_neg;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_acc     (in_acc),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .acc_q      (acc_q),
`ifdef ALU_FLAGS_EN
        .out_zero   (out_zero),
        .out_neg    (out_neg),
`endif
        .issued_cnt (issued_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic        acc;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_s;

    cmd_s        mq[$];
    logic        m_ov;
    logic [31:0] m_out;
    logic [31:0] m_acc;
    logic [15:0] m_cnt;
    logic        m_init = 1'b0;

    function automatic logic [31:0] alu_ref(input logic [2:0] sel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (sel)
            3'd0: return a;
            3'd1: return a + 32'd1;
            3'd2: return a + b;
            3'd3: return a + b + 32'd1;
            3'd4: return a + ~b;
            3'd5: return a - b;
            3'd6: return a - 32'd1;
            default: return b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check in_ready, update model, check after edge
    task automatic cycle(input logic rst_i, input logic v, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic acc, input logic clr, input logic ordy);
        cmd_s        c;
        logic        full;
        logic        issue;
        logic [31:0] res;
        @(negedge clk);
        reset     = rst_i;
        in_valid  = v;
        in_sel    = sel;
        in_a      = a;
        in_b      = b;
        in_acc    = acc;
        acc_clr   = clr;
        out_ready = ordy;
        #1;
        if (m_init) chk("in_ready", 64'(in_ready), 64'(mq.size() < 4));
        if (rst_i) begin
            mq.delete();
            m_ov   = 1'b0;
            m_out  = '0;
            m_acc  = '0;
            m_cnt  = '0;
            m_init = 1'b1;
        end else begin
            full  = (mq.size() >= 4);
            issue = (mq.size() > 0) && (!m_ov || ordy);
            if (issue) begin
                c     = mq.pop_front();
                res   = alu_ref(c.sel, c.acc ? m_acc : c.a, c.b);
                m_out = res;
                m_ov  = 1'b1;
                m_acc = res;
                m_cnt = m_cnt + 16'd1;
            end else if (ordy) begin
                m_ov = 1'b0;
            end
            if (clr) m_acc = '0;
            if (v && !full) begin
                c.acc = acc; c.sel = sel; c.a = a; c.b = b;
                mq.push_back(c);
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data", 64'(out_data), 64'(m_out));
        chk("acc_q", 64'(acc_q), 64'(m_acc));
        chk("issued_cnt", 64'(issued_cnt), 64'(m_cnt));
`ifdef ALU_FLAGS_EN
        chk("out_zero", 64'(out_zero), 64'(m_init && m_cnt != 0 && m_out == 0));
        chk("out_neg", 64'(out_neg), 64'(m_out[31]));
`endif
    endtask

    task automatic idle(input logic clr, input logic ordy);
        cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, clr, ordy);
    endtask

    task automatic push(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic acc, input logic ordy);
        cycle(1'b0, 1'b1, sel, a, b, acc, 1'b0, ordy);
    endtask

    initial begin
        int k;
        reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_a = '0; in_b = '0;
        in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

        // Reset held two cycles with in_valid asserted: nothing is pushed
        cycle(1'b1, 1'b1, 3'd2, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 3'd2, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        idle(1'b0, 1'b1);
        chk("rst_no_push", 64'(out_valid), 64'd0);

        // Single op
        push(3'b010, 32'd5, 32'd7, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        chk("single_data", 64'(out_data), 64'd12);
        chk("single_acc", 64'(acc_q), 64'd12);
        chk("single_cnt", 64'(issued_cnt), 64'd1);

        // Wrap cases
        push(3'b101, 32'd0, 32'd1, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        chk("sub_wrap", 64'(out_data), 64'hFFFF_FFFF);
        push(3'b001, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        chk("inc_wrap", 64'(out_data), 64'd0);

        // Accumulate chain
        idle(1'b1, 1'b1);
        push(3'b010, 32'd0, 32'd3, 1'b1, 1'b1);
        push(3'b010, 32'd0, 32'd3, 1'b1, 1'b1);
        chk("chain0", 64'(out_data), 64'd3);
        push(3'b010, 32'd0, 32'd3, 1'b1, 1'b1);
        chk("chain1", 64'(out_data), 64'd6);
        push(3'b010, 32'd0, 32'd3, 1'b1, 1'b1);
        chk("chain2", 64'(out_data), 64'd9);
        idle(1'b0, 1'b1);
        chk("chain3", 64'(out_data), 64'd12);
        idle(1'b0, 1'b1);

        // Backpressure: 1 held + 4 queued, 6th refused
        for (int i = 0; i < 5; i++) push(3'b111, 32'd0, 32'(100 + i), 1'b0, 1'b0);
        chk("bp_full", 64'(in_ready), 64'd0);
        push(3'b111, 32'd0, 32'd105, 1'b0, 1'b0);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if (out_valid) begin
                chk("bp_data", 64'(out_data), 64'(100 + k));
                k++;
            end
            idle(1'b0, 1'b1);
        end
        chk("bp_count", 64'(k), 64'd5);

        // Clear race
        push(3'b111, 32'd0, 32'd10, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        chk("race_pre_acc", 64'(acc_q), 64'd10);
        push(3'b001, 32'd0, 32'd0, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        chk("race_data", 64'(out_data), 64'd11);
        chk("race_acc", 64'(acc_q), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : 32'($urandom),
                  32'($urandom),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
